// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: packs 128-bit config beats into layer descriptors and runs each layer through
// DDR read, engine config, compute and write-back on one of NUM_ENG engines.
module layer_seq_ctrl #(
  parameter int NUM_ENG = 3,
  parameter int CFG_W = 512,
  parameter int MAX_LAYERS = 64,
  parameter int TIMEOUT_CYC = 0,
  localparam int LW = $clog2(MAX_LAYERS)
) (
  input  logic               I_sys_clk,
  input  logic               I_sys_rst_n,
  input  logic [127:0]       I_cfg_data,
  input  logic               I_cfg_data_valid,
  input  logic               I_abort,
  output logic [63:0]        O_cfg_rd_ddr,
  output logic               O_cfg_rd_ddr_valid,
  input  logic               I_ddr_to_mac_done,
  output logic [CFG_W-1:0]   O_eng_cfg_value,
  output logic [NUM_ENG-1:0] O_eng_cfg_valid,
  output logic [NUM_ENG-1:0] O_eng_cal_start,
  input  logic [NUM_ENG-1:0] I_eng_cal_done,
  output logic               O_relu_en,
  input  logic               I_mac_to_ddr_done,
  output logic               O_busy,
  output logic               O_task_done,
  output logic               O_err,
  output logic [1:0]         O_err_code,
  output logic [LW-1:0]      O_layer_idx,
  output logic [3:0]         O_state_debug
);
  localparam int BEATS = CFG_W / 128;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [3:0] {IDLE, FETCH, RD_DDR, CFG, START, CAL, WB, NEXT, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [CFG_W-1:0] buff [MAX_LAYERS];
  logic [CFG_W-1:0] acc, desc_w, cur, rd;
  logic [BW-1:0] bc;
  logic [LW-1:0] wptr, idx;
  logic [31:0] wd;
  logic [1:0] code, code_nx;
  logic [NUM_ENG-1:0] sel;
  logic ent, err, load, store, tmo;
  assign load = state == IDLE && I_cfg_data_valid && !I_abort;
  assign store = load && bc == BW'(BEATS - 1);
  assign tmo = TIMEOUT_CYC != 0 && wd == 32'(TIMEOUT_CYC - 1);
  assign sel = NUM_ENG'(1) << cur[67:64];
  assign rd = buff[idx];
  always_comb begin
    desc_w = acc;
    desc_w[{bc, 7'd0} +: 128] = I_cfg_data;
  end
  // wait states share the timeout code; only load and fetch raise other codes
  always_comb begin
    state_nx = state;
    code_nx = 2'd3;
    case (state)
      IDLE: begin
        state_nx = store && desc_w[69] ? FETCH : store && &wptr ? ERR : IDLE;
        code_nx = 2'd2;
      end
      FETCH: begin
        state_nx = int'(rd[67:64]) >= NUM_ENG ? ERR : RD_DDR;
        code_nx = 2'd1;
      end
      RD_DDR: state_nx = tmo ? ERR : I_ddr_to_mac_done ? CFG : RD_DDR;
      CFG: state_nx = START;
      START: state_nx = CAL;
      CAL: state_nx = tmo ? ERR : |(I_eng_cal_done & sel) ? WB : CAL;
      WB: state_nx = tmo ? ERR : I_mac_to_ddr_done ? NEXT : WB;
      NEXT: state_nx = cur[69] ? DONE : FETCH;
      DONE: state_nx = IDLE;
      default: state_nx = state;
    endcase
    if (I_abort) state_nx = IDLE;
  end
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n) begin
      state <= IDLE;
      acc <= '0;
      cur <= '0;
      bc <= '0;
      wptr <= '0;
      idx <= '0;
      wd <= '0;
      ent <= 1'b0;
      err <= 1'b0;
      code <= 2'd0;
    end else begin
      state <= state_nx;
      ent <= state_nx != state;
      wd <= state_nx != state ? 32'd0 : wd + 32'd1;
      if (I_abort) begin
        cur <= '0;
        bc <= '0;
        wptr <= '0;
        idx <= '0;
        err <= 1'b0;
        code <= 2'd0;
      end else begin
        if (load) begin
          acc <= desc_w;
          bc <= store ? '0 : bc + 1'b1;
        end
        if (store) wptr <= wptr + 1'b1;
        if (state == FETCH) cur <= rd;
        if (state == NEXT && !cur[69]) idx <= idx + 1'b1;
        if (state == DONE) begin
          wptr <= '0;
          idx <= '0;
        end
        if (state_nx == ERR && state != ERR) begin
          err <= 1'b1;
          code <= code_nx;
        end
      end
    end
  end
  always_ff @(posedge I_sys_clk) if (store) buff[wptr] <= desc_w;
  assign O_cfg_rd_ddr = cur[63:0];
  assign O_cfg_rd_ddr_valid = state == RD_DDR && ent && !I_abort;
  assign O_eng_cfg_value = cur;
  assign O_eng_cfg_valid = state == CFG && !I_abort ? sel : '0;
  assign O_eng_cal_start = state == START && !I_abort ? sel : '0;
  assign O_relu_en = cur[68];
  assign O_busy = state != IDLE;
  assign O_task_done = state == DONE && !I_abort;
  assign O_err = err;
  assign O_err_code = code;
  assign O_layer_idx = idx;
  assign O_state_debug = state;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: randomized descriptor programs checked against a queue-based transaction model.
module tb_layer_seq_ctrl;
  localparam int NE = 3, CW = 512, ML = 4, TO = 100, LW = 2;
  typedef logic [CW-1:0] desc_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [127:0] cfg_data = '0;
  logic cfg_valid = 1'b0, abort = 1'b0, ddr_done = 1'b0, mac_done = 1'b0;
  logic [NE-1:0] cal_done = '0;
  logic [63:0] rd_ddr;
  logic [CW-1:0] eng_cfg;
  logic [NE-1:0] eng_valid, cal_start;
  logic rd_ddr_valid, relu, busy, task_done, err;
  logic [1:0] err_code;
  logic [LW-1:0] layer_idx;
  logic [3:0] state_dbg;
  int checks = 0, passed = 0;

  layer_seq_ctrl #(.NUM_ENG(NE), .CFG_W(CW), .MAX_LAYERS(ML), .TIMEOUT_CYC(TO)) dut (
    .I_sys_clk(clk), .I_sys_rst_n(rst_n), .I_cfg_data(cfg_data), .I_cfg_data_valid(cfg_valid),
    .I_abort(abort), .O_cfg_rd_ddr(rd_ddr), .O_cfg_rd_ddr_valid(rd_ddr_valid),
    .I_ddr_to_mac_done(ddr_done), .O_eng_cfg_value(eng_cfg), .O_eng_cfg_valid(eng_valid),
    .O_eng_cal_start(cal_start), .I_eng_cal_done(cal_done), .O_relu_en(relu),
    .I_mac_to_ddr_done(mac_done), .O_busy(busy), .O_task_done(task_done), .O_err(err),
    .O_err_code(err_code), .O_layer_idx(layer_idx), .O_state_debug(state_dbg));

  always #5 clk = ~clk;

  function automatic desc_t make_desc(input int eng, input bit r, input bit last);
    desc_t d;
    for (int i = 0; i < CW / 32; i++) d[32*i +: 32] = $urandom;
    d[67:64] = 4'(eng);
    d[68] = r;
    d[69] = last;
    return d;
  endfunction

  task automatic send_desc(input desc_t d);
    for (int b = 0; b < CW / 128; b++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      cfg_data = d[128*b +: 128];
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_cal_start(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (cal_start !== '0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Loads the program, then plays the responder while matching each pulse to the next queued layer.
  task automatic run_prog(input desc_t q[$], input bit tie, output int cyc);
    int nr, nc, ns;
    desc_t e;
    logic [NE-1:0] oh;
    nr = 0; nc = 0; ns = 0; cyc = -1;
    foreach (q[i]) send_desc(q[i]);
    for (int c = 0; c < 500; c++) begin
      if (rd_ddr_valid) begin
        e = nr < q.size() ? q[nr] : '0;
        checks++;
        if (nr >= q.size() || rd_ddr !== e[63:0])
          $display("FAIL rd_ddr layer %0d: got %h exp %h", nr, rd_ddr, e[63:0]);
        else passed++;
        nr++;
      end
      if (eng_valid !== '0) begin
        e = nc < q.size() ? q[nc] : '0;
        oh = NE'(1) << e[67:64];
        checks++;
        if (nc >= q.size() || eng_valid !== oh || eng_cfg !== e || relu !== e[68] || layer_idx !== LW'(nc))
          $display("FAIL eng_cfg layer %0d: got valid %b idx %0d relu %b exp valid %b idx %0d relu %b",
                   nc, eng_valid, layer_idx, relu, oh, nc, e[68]);
        else passed++;
        nc++;
      end
      if (cal_start !== '0) begin
        e = ns < q.size() ? q[ns] : '0;
        oh = NE'(1) << e[67:64];
        checks++;
        if (ns >= q.size() || cal_start !== oh)
          $display("FAIL cal_start layer %0d: got %b exp %b", ns, cal_start, oh);
        else passed++;
        ns++;
      end
      if (task_done) begin
        cyc = c;
        break;
      end
      ddr_done = tie | ($urandom_range(0, 2) == 0);
      mac_done = tie | ($urandom_range(0, 2) == 0);
      cal_done = tie ? '1 : NE'($urandom);
      @(negedge clk);
    end
    ddr_done = 1'b0; mac_done = 1'b0; cal_done = '0;
    checks++;
    if (cyc < 0) $display("FAIL task_done: got none exp pulse"); else passed++;
    checks++;
    if (nr != q.size() || nc != q.size() || ns != q.size())
      $display("FAIL pulse_counts: got rd %0d cfg %0d start %0d exp %0d", nr, nc, ns, q.size());
    else passed++;
    @(negedge clk);
    checks++;
    if ({busy, err} !== 2'b00) $display("FAIL idle_after_done: got busy %b err %b exp 0 0", busy, err);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, err, err_code, layer_idx, state_dbg, task_done} !== '0)
      $display("FAIL reset_ctrl: got %h exp 0", {busy, err, err_code, layer_idx, state_dbg, task_done});
    else passed++;
    checks++;
    if ({rd_ddr, rd_ddr_valid, eng_valid, cal_start, relu} !== '0)
      $display("FAIL reset_data: got %h exp 0", {rd_ddr, rd_ddr_valid, eng_valid, cal_start, relu});
    else passed++;
    checks++;
    if (eng_cfg !== '0) $display("FAIL reset_cfg: got %h exp 0", eng_cfg); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    desc_t q[$];
    int cyc;
    q.push_back(make_desc(2, 1'($urandom_range(0, 1)), 1'b0));
    q.push_back(make_desc(0, 1'($urandom_range(0, 1)), 1'b1));
    run_prog(q, 1'b0, cyc);
  endtask

  task automatic test_min_latency();
    desc_t q[$];
    int cyc;
    for (int n = 2; n <= 3; n++) begin
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(make_desc($urandom_range(0, NE - 1), 1'b0, i == n - 1));
      run_prog(q, 1'b1, cyc);
      checks++;
      if (cyc != 7 * n) $display("FAIL min_latency %0d layers: got %0d exp %0d", n, cyc, 7 * n);
      else passed++;
    end
  endtask

  task automatic test_random();
    desc_t q[$];
    int cyc, n;
    repeat (4) begin
      q.delete();
      n = $urandom_range(1, ML);
      for (int i = 0; i < n; i++)
        q.push_back(make_desc($urandom_range(0, NE - 1), 1'($urandom_range(0, 1)), i == n - 1));
      run_prog(q, 1'b0, cyc);
    end
  endtask

  task automatic test_bad_engine();
    bit pulsed;
    pulsed = 1'b0;
    send_desc(make_desc($urandom_range(NE, 15), 1'b0, 1'b1));
    ddr_done = 1'b1; cal_done = '1; mac_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({err, err_code} !== 3'b101) $display("FAIL bad_eng_err: got %b exp 101", {err, err_code});
    else passed++;
    repeat (5) begin
      pulsed |= (cal_start !== '0) | (eng_valid !== '0) | rd_ddr_valid;
      @(negedge clk);
    end
    checks++;
    if (pulsed || !busy || !err) $display("FAIL bad_eng_hold: got pulsed %b busy %b err %b exp 0 1 1", pulsed, busy, err);
    else passed++;
    do_abort();
    ddr_done = 1'b0; cal_done = '0; mac_done = 1'b0;
    checks++;
    if ({busy, err, err_code} !== 4'b0000) $display("FAIL bad_eng_abort: got %b exp 0000", {busy, err, err_code});
    else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < ML; i++) begin
      send_desc(make_desc($urandom_range(0, NE - 1), 1'b0, 1'b0));
      if (i < ML - 1) begin
        checks++;
        if ({busy, err} !== 2'b00) $display("FAIL overflow_early write %0d: got busy %b err %b exp 0 0", i, busy, err);
        else passed++;
      end
    end
    checks++;
    if ({busy, err, err_code} !== 4'b1110) $display("FAIL overflow: got %b exp 1110", {busy, err, err_code});
    else passed++;
    do_abort();
    checks++;
    if ({busy, err} !== 2'b00) $display("FAIL overflow_abort: got %b exp 00", {busy, err}); else passed++;
  endtask

  task automatic test_timeout();
    int eng, n;
    logic [NE-1:0] oh;
    bit got;
    eng = $urandom_range(0, NE - 1);
    oh = NE'(1) << eng;
    send_desc(make_desc(eng, 1'b0, 1'b1));
    ddr_done = 1'b1; mac_done = 1'b1; cal_done = ~oh;
    wait_cal_start(got);
    checks++;
    if (!got) $display("FAIL timeout_reach_cal: got no cal_start exp pulse"); else passed++;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    checks++;
    if (n - 1 != TO) $display("FAIL timeout_cycles: got %0d exp %0d", n - 1, TO); else passed++;
    checks++;
    if ({busy, err, err_code} !== 4'b1111) $display("FAIL timeout_err: got %b exp 1111", {busy, err, err_code});
    else passed++;
    cal_done = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({err, err_code} !== 3'b111) $display("FAIL timeout_sticky: got %b exp 111", {err, err_code}); else passed++;
    do_abort();
    ddr_done = 1'b0; mac_done = 1'b0; cal_done = '0;
    checks++;
    if ({busy, err, err_code} !== 4'b0000) $display("FAIL timeout_abort: got %b exp 0000", {busy, err, err_code});
    else passed++;
  endtask

  task automatic test_drop_beats();
    bit got;
    int eng;
    eng = $urandom_range(0, NE - 1);
    send_desc(make_desc(eng, 1'b0, 1'b1));
    ddr_done = 1'b1; mac_done = 1'b1; cal_done = '0;
    wait_cal_start(got);
    @(negedge clk);
    repeat (2) begin
      cfg_data = {$urandom, $urandom, $urandom, $urandom};
      cfg_valid = 1'b1;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    checks++;
    if (!got || {busy, err} !== 2'b10) $display("FAIL drop_in_cal: got cal %b busy %b err %b exp 1 1 0", got, busy, err);
    else passed++;
    cal_done = '1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (task_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    ddr_done = 1'b0; mac_done = 1'b0; cal_done = '0;
    checks++;
    if (!got) $display("FAIL drop_finish: got no task_done exp pulse"); else passed++;
    @(negedge clk);
    test_sequence();
  endtask

  task automatic test_reset_mid_wb();
    bit got;
    send_desc(make_desc($urandom_range(0, NE - 1), 1'b1, 1'b1));
    ddr_done = 1'b1; cal_done = '1; mac_done = 1'b0;
    wait_cal_start(got);
    repeat (2) @(negedge clk);
    checks++;
    if (!got || !busy || task_done) $display("FAIL wb_reached: got cal %b busy %b done %b exp 1 1 0", got, busy, task_done);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, err, err_code, layer_idx, state_dbg, task_done, rd_ddr_valid, eng_valid, cal_start, relu, rd_ddr} !== '0)
      $display("FAIL reset_mid_wb_ctrl: got %h exp 0",
               {busy, err, err_code, layer_idx, state_dbg, task_done, rd_ddr_valid, eng_valid, cal_start, relu, rd_ddr});
    else passed++;
    checks++;
    if (eng_cfg !== '0) $display("FAIL reset_mid_wb_cfg: got %h exp 0", eng_cfg); else passed++;
    ddr_done = 1'b0; cal_done = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_min_latency();
    test_random();
    test_bad_engine();
    test_overflow();
    test_timeout();
    test_drop_beats();
    test_reset_mid_wb();
    test_sequence();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
